// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a framed word stream (header, N payload words, XOR checksum) over a
// valid/ready handshake and writes the payload into instruction memory at
// consecutive word addresses. The core is held in reset until a frame loads
// with a matching checksum.
//
// Ports:
//   clk, rst       - clock; asynchronous active-low reset
//   in_valid/in_ready/in_data - stream input handshake
//   rearm          - pulse in DONE/ERR to wait for a new frame
//   mem_we/mem_addr/mem_wdata - registered instruction memory write port
//   core_hold      - high holds the core in reset
//   done / err     - frame loaded OK / checksum mismatch
//   words_written  - payload words written in the current or last frame
module imem_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_written
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0]   words_q, words_d;
  logic [DATA_W-1:0]   xor_q, xor_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ready_q, ready_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                fire;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HDR;
      addr_cnt_q  <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b1;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      xor_q       <= xor_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fire        = in_valid && ready_q;

    case (state_q)
      S_HDR: begin
        if (fire) begin
          addr_cnt_d  = in_data[ADDR_W-1:0];
          remaining_d = in_data[2*ADDR_W-1:ADDR_W];
          xor_d       = '0;
          words_d     = '0;
          state_d     = (in_data[2*ADDR_W-1:ADDR_W] != '0) ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        if (fire) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_cnt_q;
          mem_wdata_d = in_data;
          xor_d       = xor_q ^ in_data;
          addr_cnt_d  = addr_cnt_q + ADDR_W'(1);  // wraps mod 2^ADDR_W
          words_d     = words_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (fire) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        if (rearm) state_d = S_HDR;
      end
      S_ERR: begin
        if (rearm) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    // Status outputs are registered copies of the next-state decode
    ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  assign in_ready      = ready_q;
  assign core_hold     = hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes the expected write for
// each payload transfer; a negedge monitor pops and checks each mem_we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        rearm;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rearm(rearm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every mem_we pulse must match the oldest expected write and
  // appear exactly one cycle after its transfer.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (sb_q.size() == 0) begin
        check("spurious_mem_we", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
        check("wr_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
    cyc++;
  end

  // Offer one word until it transfers; payload transfers push an expected write.
  task automatic send_word(input logic [31:0] data, input bit rnd, input bit is_payload,
                           input logic [15:0] addr);
    bit fired = 0;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(posedge clk); #1;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? data : $urandom;
      if (in_valid && in_ready) begin
        fired = 1;
        if (is_payload) sb_q.push_back('{addr: addr, data: data, cyc: cyc});
      end
    end
    if (!fired) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] pl[$],
                            input logic [31:0] csum, input bit rnd);
    logic [15:0] a;
    a = hdr[15:0];
    send_word(hdr, rnd, 1'b0, 16'h0);
    foreach (pl[i]) begin
      send_word(pl[i], rnd, 1'b1, a);
      a = a + 16'd1;
    end
    send_word(csum, rnd, 1'b0, 16'h0);
    idle();
  endtask

  // Checked right after the checksum edge, then once more after the monitor drains.
  task automatic check_end(input string tag, input bit exp_done, input logic [15:0] exp_words);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(!exp_done));
    check({tag, "_hold"}, 32'(core_hold), 32'(!exp_done));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'(exp_words));
    @(negedge clk);
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_rearm();
    @(posedge clk); #1 rearm = 1'b1;
    @(posedge clk); #1 rearm = 1'b0;
    check("rearm_ready", 32'(in_ready), 32'd1);
    check("rearm_hold", 32'(core_hold), 32'd1);
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_err", 32'(err), 32'd0);
  endtask

  logic [31:0] basic[$];
  logic [31:0] wrapw[$];
  logic [31:0] none[$];

  initial begin
    basic = '{32'hAAAA0001, 32'h00000002, 32'h12345678};
    wrapw = '{32'h11111111, 32'h22222222, 32'h44444444};
    none  = {};
    rst = 1'b0; in_valid = 1'b0; in_data = '0; rearm = 1'b0;
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_hold", 32'(core_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    rst = 1'b1;

    // Basic load; checksum A003^... = 0xB89E567B
    send_frame(32'h0003_0010, basic, 32'hB89E_567B, 1'b0);
    check_end("basic", 1'b1, 16'd3);
    do_rearm();
    // rearm outside DONE/ERR has no effect
    @(posedge clk); #1 rearm = 1'b1;
    @(posedge clk); #1 rearm = 1'b0;
    check("rearm_in_hdr_ready", 32'(in_ready), 32'd1);

    // Bad checksum: writes still land, then ERR
    send_frame(32'h0003_0010, basic, 32'h0000_0000, 1'b0);
    check_end("badcsum", 1'b0, 16'd3);
    do_rearm();
    send_frame(32'h0003_0010, basic, 32'hB89E_567B, 1'b0);
    check_end("recover", 1'b1, 16'd3);
    do_rearm();

    // Empty frame
    send_frame(32'h0000_1234, none, 32'h0, 1'b0);
    check_end("empty", 1'b1, 16'd0);
    do_rearm();

    // Address wrap 0xFFFE, 0xFFFF, 0x0000
    send_frame(32'h0003_FFFE, wrapw, 32'h7777_7777, 1'b0);
    check_end("wrap", 1'b1, 16'd3);
    do_rearm();

    // Random in_valid stalls
    send_frame(32'h0003_0010, basic, 32'hB89E_567B, 1'b1);
    check_end("stall", 1'b1, 16'd3);
    do_rearm();

    // Async reset right after the 2nd payload transfer, off the edge
    send_word(32'h0003_0010, 1'b0, 1'b0, 16'h0);
    send_word(basic[0], 1'b0, 1'b1, 16'h0010);
    send_word(basic[1], 1'b0, 1'b1, 16'h0011);
    @(posedge clk); #1 in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_hold", 32'(core_hold), 32'd1);
    check("arst_words", 32'(words_written), 32'd0);
    check("arst_pending", 32'(sb_q.size()), 32'd1);
    sb_q.delete();  // the dropped 2nd write is expected never to appear
    #10 rst = 1'b1;
    send_frame(32'h0003_0010, basic, 32'hB89E_567B, 1'b0);
    check_end("after_rst", 1'b1, 16'd3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
